seq_mult: RTL and testbench

Parametrised sequential shift-add multiplier for the simple CPU ALU; replaces the fixed 8-bit combinational array multiplier. Computes the full 2*WIDTH product over multiple cycles, with start/busy/done handshake, signed or unsigned mode, and an overflow flag. OUT carries the truncated low WIDTH bits for the register file write-back path; PRODUCT carries the full result.

---
 rtl/seq_mult.sv | 131 +++++++++++++
 tb/tb_seq_mult.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier with start/busy/done handshake, signed or unsigned operands.
// Optional macro EARLY_TERM_EN stops iterating once the remaining multiplier bits are zero.
module seq_mult #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               CLK,
    input  logic               RESETN,
    input  logic               START,
    input  logic               SIGNED_MODE,
    input  logic [WIDTH-1:0]   MULTIPLICAND,
    input  logic [WIDTH-1:0]   MULTIPLIER,
    output logic               BUSY,
    output logic               DONE,
    output logic [2*WIDTH-1:0] PRODUCT,
    output logic [WIDTH-1:0]   OUT,
    output logic               OVF
);

    localparam int PW = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;
    logic             sgn_q, sgn_d;
    logic [PW-1:0]    product_q, product_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [PW-1:0]    prod_fix;
    logic [WIDTH:0]   prod_hi;
    logic             ovf_fix;

    // -(-2^(W-1)) wraps back to 2^(W-1), which is the correct unsigned magnitude
    assign mag_a = (SIGNED_MODE && MULTIPLICAND[WIDTH-1]) ? -MULTIPLICAND : MULTIPLICAND;
    assign mag_b = (SIGNED_MODE && MULTIPLIER[WIDTH-1])   ? -MULTIPLIER   : MULTIPLIER;

    assign prod_fix = neg_q ? -acc_q : acc_q;
    assign prod_hi  = prod_fix[PW-1:WIDTH-1];
    assign ovf_fix  = sgn_q ? !((&prod_hi) || (~|prod_hi)) : (|prod_fix[PW-1:WIDTH]);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        sgn_d     = sgn_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (START) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    neg_d    = SIGNED_MODE & (MULTIPLICAND[WIDTH-1] ^ MULTIPLIER[WIDTH-1]);
                    sgn_d    = SIGNED_MODE;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
`ifdef EARLY_TERM_EN
                    if ((MULTIPLIER == '0) || (MULTIPLICAND == '0))
                        state_d = FIX;
`endif
                end
            end
            CALC: begin
                if (mplier_q[0])
                    acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST)
                    state_d = FIX;
`ifdef EARLY_TERM_EN
                if (mplier_q[WIDTH-1:1] == '0)
                    state_d = FIX;
`endif
            end
            FIX: begin
                product_d = prod_fix;
                ovf_d     = ovf_fix;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            sgn_q     <= 1'b0;
            product_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            sgn_q     <= sgn_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign BUSY    = (state_q == CALC) || (state_q == FIX);
    assign DONE    = done_q;
    assign PRODUCT = product_q;
    assign OUT     = product_q[WIDTH-1:0];
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_seq_mult.sv
// Bench for seq_mult (WIDTH=8): arithmetic reference model checked every cycle, plus directed literal vectors.
module tb_seq_mult;

    localparam int W = 8;
`ifdef EARLY_TERM_EN
    localparam bit ET = 1'b1;
`else
    localparam bit ET = 1'b0;
`endif

    logic          CLK, RESETN, START, SIGNED_MODE;
    logic [W-1:0]  MULTIPLICAND, MULTIPLIER;
    logic          BUSY, DONE, OVF;
    logic [2*W-1:0] PRODUCT;
    logic [W-1:0]  OUT;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    seq_mult #(.WIDTH(W)) dut (
        .CLK(CLK), .RESETN(RESETN), .START(START), .SIGNED_MODE(SIGNED_MODE),
        .MULTIPLICAND(MULTIPLICAND), .MULTIPLIER(MULTIPLIER),
        .BUSY(BUSY), .DONE(DONE), .PRODUCT(PRODUCT), .OUT(OUT), .OVF(OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int f_full(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        int sa, sb;
        sa = sm ? int'($signed(a)) : int'(a);
        sb = sm ? int'($signed(b)) : int'(b);
        return sa * sb;
    endfunction

    function automatic logic [2*W-1:0] f_prod(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        int p;
        p = f_full(a, b, sm);
        return p[2*W-1:0];
    endfunction

    function automatic logic f_ovf(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        int p;
        p = f_full(a, b, sm);
        return sm ? (p < -128 || p > 127) : (p > 255);
    endfunction

    // edges from the START edge until DONE is visible
    function automatic int f_lat(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        int mag, msb;
        if (!ET) return W + 1;
        if (a == 0 || b == 0) return 1;
        mag = (sm && b[W-1]) ? -int'($signed(b)) : int'(b);
        msb = 0;
        for (int i = 0; i < W + 1; i++)
            if (((mag >> i) & 1) == 1) msb = i;
        return msb + 2;
    endfunction

    int             m_cd = 0;
    logic           m_done = 1'b0;
    logic [2*W-1:0] m_prod = '0;
    logic           m_ovf = 1'b0;
    logic [2*W-1:0] pend_prod = '0;
    logic           pend_ovf = 1'b0;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_cd   <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_ovf  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_cd > 0) begin
                m_cd <= m_cd - 1;
                if (m_cd == 1) begin
                    m_done <= 1'b1;
                    m_prod <= pend_prod;
                    m_ovf  <= pend_ovf;
                end
            end else if (START) begin
                pend_prod <= f_prod(MULTIPLICAND, MULTIPLIER, SIGNED_MODE);
                pend_ovf  <= f_ovf(MULTIPLICAND, MULTIPLIER, SIGNED_MODE);
                m_cd      <= f_lat(MULTIPLICAND, MULTIPLIER, SIGNED_MODE);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            check("BUSY", 32'(BUSY), 32'(m_cd != 0));
            check("DONE", 32'(DONE), 32'(m_done));
            check("PRODUCT", 32'(PRODUCT), 32'(m_prod));
            check("OUT", 32'(OUT), 32'(m_prod[W-1:0]));
            check("OVF", 32'(OVF), 32'(m_ovf));
        end
    end

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm);
        START = 1'b1; MULTIPLICAND = a; MULTIPLIER = b; SIGNED_MODE = sm;
        @(posedge CLK); #2;
        START = 1'b0; MULTIPLICAND = $urandom_range(0, 255); MULTIPLIER = $urandom_range(0, 255);
        SIGNED_MODE = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(posedge CLK); #2;
            if (DONE) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          input logic [2*W-1:0] prod, input logic ovf, input int lat);
        int l;
        start_op(a, b, sm);
        check({name, "_busy"}, 32'(BUSY), 32'(1));
        wait_done(l);
        check({name, "_lat"}, 32'(l), 32'(lat));
        check({name, "_product"}, 32'(PRODUCT), 32'(prod));
        check({name, "_out"}, 32'(OUT), 32'(prod[W-1:0]));
        check({name, "_ovf"}, 32'(OVF), 32'(ovf));
        check({name, "_model"}, 32'(m_prod), 32'(prod));
    endtask

    initial begin
        int l;
        RESETN = 1'b1; START = 1'b0; SIGNED_MODE = 1'b0; MULTIPLICAND = '0; MULTIPLIER = '0;
        #1 RESETN = 1'b0;
        #3 chk_en = 1'b1;
        @(posedge CLK); #2;
        check("rst_busy", 32'(BUSY), 32'(0));
        check("rst_done", 32'(DONE), 32'(0));
        check("rst_product", 32'(PRODUCT), 32'(0));
        check("rst_ovf", 32'(OVF), 32'(0));
        @(posedge CLK); #2;
        RESETN = 1'b1;
        @(posedge CLK); #2;

        run_op("u13x11", 8'd13, 8'd11, 1'b0, 16'h008F, 1'b0, ET ? 5 : 9);
        run_op("u255x255", 8'd255, 8'd255, 1'b0, 16'hFE01, 1'b1, 9);
        run_op("sm3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1, 1'b0, ET ? 4 : 9);
        run_op("s80x80", 8'h80, 8'h80, 1'b1, 16'h4000, 1'b1, 9);
        run_op("u16x16", 8'd16, 8'd16, 1'b0, 16'h0100, 1'b1, ET ? 6 : 9);
        run_op("s80x01", 8'h80, 8'h01, 1'b1, 16'hFF80, 1'b0, ET ? 2 : 9);
        run_op("s7Fx01", 8'h7F, 8'h01, 1'b1, 16'h007F, 1'b0, ET ? 2 : 9);
        run_op("sFFxFF", 8'hFF, 8'hFF, 1'b1, 16'h0001, 1'b0, ET ? 2 : 9);
        run_op("u7x1", 8'd7, 8'd1, 1'b0, 16'h0007, 1'b0, ET ? 2 : 9);
        run_op("u9x0", 8'd9, 8'd0, 1'b0, 16'h0000, 1'b0, ET ? 1 : 9);
        run_op("u0x5", 8'd0, 8'd5, 1'b0, 16'h0000, 1'b0, ET ? 1 : 9);

        // START while busy is ignored; START in the DONE cycle is accepted
        start_op(8'd13, 8'd11, 1'b0);
        repeat (2) begin @(posedge CLK); #2; end
        START = 1'b1; MULTIPLICAND = 8'd2; MULTIPLIER = 8'd2; SIGNED_MODE = 1'b0;
        @(posedge CLK); #2;
        START = 1'b0;
        wait_done(l);
        check("busy_start_lat", 32'(l), 32'(ET ? 2 : 6));
        check("busy_start_product", 32'(PRODUCT), 32'h008F);
        run_op("done_cycle_start", 8'd2, 8'd2, 1'b0, 16'h0004, 1'b0, ET ? 3 : 9);

        // reset mid-operation aborts with no DONE
        start_op(8'd13, 8'd11, 1'b0);
        repeat (3) begin @(posedge CLK); #2; end
        RESETN = 1'b0;
        #1;
        check("midrst_busy", 32'(BUSY), 32'(0));
        check("midrst_done", 32'(DONE), 32'(0));
        check("midrst_product", 32'(PRODUCT), 32'(0));
        check("midrst_ovf", 32'(OVF), 32'(0));
        @(posedge CLK); #2;
        RESETN = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge CLK); #2;
            check("no_done_after_rst", 32'(DONE), 32'(0));
        end
        run_op("after_rst", 8'd13, 8'd11, 1'b0, 16'h008F, 1'b0, ET ? 5 : 9);

        repeat (3) @(posedge CLK);
        #2 chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
